// File: rtl/aquarius_uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchronizer, mid-bit sampling and a
// small receive FIFO with sticky framing-error and overrun flags.
module aquarius_uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       err_clr,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   FULL_CNT = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    sync_q, sync_d;
  logic          prev_q, prev_d;
  logic          armed_q, armed_d;
  logic [1:0]    settle_q, settle_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          rx_valid_q, rx_valid_d;
  logic          busy_q, busy_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic rxd_s;
  logic push, frame_set, pop, full, wr_en, ovf_set;

  assign rxd_s = sync_q[1];

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    sync_d    = {sync_q[0], rxd};
    prev_d    = rxd_s;
    push      = 1'b0;
    frame_set = 1'b0;

    // The synchronizer holds reset values for two cycles; only a high level
    // seen after that may arm start detection (also re-arms after a break).
    settle_d = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
    armed_d  = armed_q | ((settle_q == 2'd2) & rxd_s);

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (armed_q && prev_q && !rxd_s) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d     = '0;
          bit_cnt_d = '0;
          state_d   = rxd_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d     = '0;
          shift_d   = {rxd_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rxd_s) begin
            push = 1'b1;
          end else begin
            frame_set = 1'b1;
            armed_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    pop     = rx_valid_q & rx_ready;
    full    = (count_q == FULL_CNT);
    wr_en   = push & (~full | pop);
    ovf_set = push & full & ~pop;

    wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + (PW + 1)'(1);
      2'b01:   count_d = count_q - (PW + 1)'(1);
      default: count_d = count_q;
    endcase

    rx_valid_d  = (count_d != '0);
    busy_d      = (state_d != IDLE);
    frame_err_d = (frame_err_q & ~err_clr) | frame_set;
    overrun_d   = (overrun_q & ~err_clr) | ovf_set;
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge value of every other flop.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      sync_q      <= 2'b11;
      prev_q      <= 1'b1;
      armed_q     <= 1'b0;
      settle_q    <= 2'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      sync_q      <= sync_d;
      prev_q      <= prev_d;
      armed_q     <= armed_d;
      settle_q    <= settle_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rx_valid_q  <= rx_valid_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // NOTE: the storage array is not reset; an entry is only read after it has
  // been written, and the pointers/count carry the reset state.
  always_ff @(posedge clk_sys) begin
    if (wr_en) mem_q[wr_ptr_q] <= shift_q;
  end

  assign rx_data   = mem_q[rd_ptr_q];
  assign rx_valid  = rx_valid_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_aquarius_uart_rx.sv
// Directed + randomized bench for aquarius_uart_rx (16 clocks/bit, 4-deep FIFO)
// against a queue-based model of the receive path.
module tb_aquarius_uart_rx;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       err_clr;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] model_q [$];
  bit         ex_ferr;
  bit         ex_ovr;

  aquarius_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .rxd      (rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .err_clr  (err_clr),
    .busy     (busy)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_sys);
  endtask

  // Drives one frame starting at a falling edge. The stop sample lands 11
  // clocks into the stop bit (2 sync + 1 detect + half bit + 9 full bits),
  // so rx_ready/err_clr pulses at that offset coincide with the push.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                            input bit rdy_at_push, input bit clr_at_push,
                            input bit chk_latency);
    logic [9:0] frame;
    frame = {stop_ok, b, 1'b0};
    for (int j = 0; j < 10; j++) begin
      rxd = frame[j];
      for (int k = 0; k < CPB; k++) begin
        if (j == 9) begin
          rx_ready = rdy_at_push && (k == 11);
          err_clr  = clr_at_push && (k == 11);
          if (chk_latency && k == 11) check("valid_before_push", 8'(rx_valid), 8'd0);
          if (chk_latency && k == 12) check("valid_after_push", 8'(rx_valid), 8'd1);
        end
        @(negedge clk_sys);
      end
    end
    rx_ready = 1'b0;
    err_clr  = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, 8'(rx_valid), 8'd1);
    check({tag, "_data"}, rx_data, exp);
    rx_ready = 1'b1;
    @(negedge clk_sys);
    rx_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk_sys);
    err_clr = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    bit         ok;
    bit         busy_cleared;
    logic [9:0] frame;

    reset = 1'b1; rxd = 1'b1; rx_ready = 1'b0; err_clr = 1'b0;
    idle(3);
    check("rst_busy", 8'(busy), 8'd0);
    check("rst_valid", 8'(rx_valid), 8'd0);
    check("rst_ferr", 8'(frame_err), 8'd0);
    check("rst_ovr", 8'(overrun), 8'd0);
    reset = 1'b0;
    idle(6);

    // Single byte held until accepted
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
    check("a5_valid", 8'(rx_valid), 8'd1);
    check("a5_data", rx_data, 8'hA5);
    idle(20);
    check("a5_hold_valid", 8'(rx_valid), 8'd1);
    check("a5_hold_data", rx_data, 8'hA5);
    rx_ready = 1'b1;
    @(negedge clk_sys);
    rx_ready = 1'b0;
    check("a5_popped", 8'(rx_valid), 8'd0);
    idle(4);

    // Start-bit glitch is rejected
    rxd = 1'b0;
    idle(5);
    rxd = 1'b1;
    check("glitch_busy", 8'(busy), 8'd1);
    busy_cleared = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!busy) begin
        busy_cleared = 1'b1;
        break;
      end
      @(negedge clk_sys);
    end
    check("glitch_busy_clear", 8'(busy_cleared), 8'd1);
    check("glitch_valid", 8'(rx_valid), 8'd0);
    check("glitch_ferr", 8'(frame_err), 8'd0);
    idle(5);

    // Framing error, then a held break must not start a new frame
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(40);
    check("break_busy", 8'(busy), 8'd0);
    check("ferr_set", 8'(frame_err), 8'd1);
    check("ferr_valid", 8'(rx_valid), 8'd0);
    rxd = 1'b1;
    idle(4);
    pulse_clr();
    check("ferr_clr", 8'(frame_err), 8'd0);

    // err_clr coinciding with a framing error: the set wins
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
    check("ferr_set_wins", 8'(frame_err), 8'd1);
    rxd = 1'b1;
    idle(4);
    pulse_clr();
    check("ferr_clr2", 8'(frame_err), 8'd0);

    // Overflow: five back-to-back bytes into a four-entry FIFO
    for (int v = 1; v <= 5; v++) send_frame(8'(v), 1'b1, 1'b0, 1'b0, 1'b0);
    check("ovr_set", 8'(overrun), 8'd1);
    for (int v = 1; v <= 4; v++) pop_check("ovr_drain", 8'(v));
    check("ovr_empty", 8'(rx_valid), 8'd0);
    pulse_clr();
    check("ovr_clr", 8'(overrun), 8'd0);

    // Push and pop in the same cycle on a full FIFO
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h44, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h77, 1'b1, 1'b1, 1'b0, 1'b0);
    check("full_pp_ovr", 8'(overrun), 8'd0);
    pop_check("full_pp", 8'h22);
    pop_check("full_pp", 8'h33);
    pop_check("full_pp", 8'h44);
    pop_check("full_pp", 8'h77);
    check("full_pp_empty", 8'(rx_valid), 8'd0);
    idle(4);

    // Reset during data bit 3
    frame = {1'b1, 8'hC3, 1'b0};
    for (int j = 0; j < 4; j++) begin
      rxd = frame[j];
      idle(CPB);
    end
    rxd = frame[4];
    idle(8);
    reset = 1'b1;
    rxd   = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    check("midrst_busy", 8'(busy), 8'd0);
    check("midrst_valid", 8'(rx_valid), 8'd0);
    check("midrst_ferr", 8'(frame_err), 8'd0);
    idle(20);
    check("midrst_idle", 8'(busy), 8'd0);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b1);
    pop_check("after_rst", 8'h5A);

    // Reset released with the line low: no start until it rises and falls
    rxd   = 1'b0;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(40);
    check("low_rst_busy", 8'(busy), 8'd0);
    check("low_rst_valid", 8'(rx_valid), 8'd0);
    rxd = 1'b1;
    idle(8);
    send_frame(8'h96, 1'b1, 1'b0, 1'b0, 1'b0);
    pop_check("low_rst_rx", 8'h96);
    idle(4);

    // Random frames against the queue model
    model_q.delete();
    ex_ferr = 1'b0;
    ex_ovr  = 1'b0;
    for (int n = 0; n < 10; n++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(3) != 0);
      send_frame(b, ok, 1'b0, 1'b0, 1'b0);
      rxd = 1'b1;
      if (ok) begin
        if (model_q.size() < DEPTH) model_q.push_back(b);
        else ex_ovr = 1'b1;
      end else begin
        ex_ferr = 1'b1;
      end
      idle(4);
      check("rand_ferr", 8'(frame_err), 8'(ex_ferr));
      check("rand_ovr", 8'(overrun), 8'(ex_ovr));
      check("rand_valid", 8'(rx_valid), 8'(model_q.size() != 0));
      if (model_q.size() != 0 && $urandom_range(1) == 1)
        pop_check("rand_pop", model_q.pop_front());
    end
    while (model_q.size() != 0) pop_check("rand_drain", model_q.pop_front());
    check("rand_empty", 8'(rx_valid), 8'd0);
    pulse_clr();
    check("rand_clr_ferr", 8'(frame_err), 8'd0);
    check("rand_clr_ovr", 8'(overrun), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aquarius_uart_rx.md
AQUARIUS_UART_RX -- requirements
Module: aquarius_uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, SHALL set clk_sys cycles per serial bit (legal range >= 16; 434 gives 115200 baud at 50 MHz).
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set receive FIFO entries (power of two, >= 2).
REQ-003 clk_sys  input  1  SHALL be the single system clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be the reset, synchronous, active-high.
REQ-005 rxd  input  1  SHALL be the asynchronous serial line (8N1, LSB first, idle high).
REQ-006 rx_data  output  8  SHALL present the byte at the FIFO head.
REQ-007 rx_valid  output  1  SHALL indicate the FIFO is non-empty.
REQ-008 rx_ready  input  1  SHALL indicate the consumer accepts rx_data this cycle.
REQ-009 frame_err  output  1  SHALL be a sticky framing-error flag.
REQ-010 overrun  output  1  SHALL be a sticky FIFO-overflow flag.
REQ-011 err_clr  input  1  SHALL clear frame_err and overrun.
REQ-012 busy  output  1  SHALL indicate a frame is in progress.

Function
REQ-013 rxd SHALL pass through a 2-flop synchronizer before use; all decoding SHALL use the synchronized value rxd_s.
REQ-014 The receiver SHALL implement states IDLE, START, DATA, STOP; busy SHALL be 1 exactly when the state is not IDLE.
REQ-015 IDLE: a falling edge on rxd_s (previous 1, current 0) SHALL move to START and clear the bit-timing counter.
REQ-016 START: when the counter reaches CLKS_PER_BIT/2 (integer division), rxd_s SHALL be sampled; 0 -> DATA with counter cleared; 1 -> IDLE with no byte and no error (glitch rejection).
REQ-017 DATA: every CLKS_PER_BIT cycles rxd_s SHALL be sampled and shifted in LSB first; after the 8th sample the state SHALL become STOP.
REQ-018 STOP: after CLKS_PER_BIT cycles rxd_s SHALL be sampled; 1 -> byte pushed to FIFO; 0 -> byte discarded and frame_err set; either way -> IDLE.
REQ-019 After a stop-bit sample of 0, IDLE SHALL NOT detect a new start until rxd_s has been observed high for at least one cycle (break handling).
REQ-020 The bit-timing counter SHALL be $clog2(CLKS_PER_BIT) bits wide and SHALL not wrap within a bit period.
REQ-021 A pushed byte SHALL appear with rx_valid = 1 on the cycle after the stop-sample cycle.
REQ-022 A FIFO pop SHALL occur on any cycle with rx_valid and rx_ready both 1; rx_ready while rx_valid = 0 SHALL have no effect.
REQ-023 rx_data SHALL be meaningful only while rx_valid = 1, and SHALL remain stable while rx_valid = 1 and rx_ready = 0.
REQ-024 A push into a full FIFO with no pop in the same cycle SHALL drop the new byte, keep stored bytes unchanged, and set overrun.
REQ-025 A push and a pop in the same cycle on a full FIFO SHALL both complete, with overrun unchanged.
REQ-026 Bytes SHALL be delivered in arrival order; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 err_clr SHALL clear both flags on the next edge; if a set event coincides with err_clr, the set SHALL win.

Reset
REQ-028 While reset = 1 on a clock edge, the following SHALL hold: state = IDLE; FIFO pointers and count = 0; synchronizer flops = 1; rx_valid = 0, busy = 0, frame_err = 0, overrun = 0.
REQ-029 Reset asserted mid-frame SHALL abandon the partial byte with no push and no error flag.
REQ-030 After reset release with rxd held low, no start SHALL be detected until rxd goes high and then falls.

Verification (CLKS_PER_BIT = 16, FIFO_DEPTH = 4)
REQ-031 Send 0xA5 8N1 with rx_ready = 0 -> rx_valid = 1, rx_data = 0xA5, held stable; one rx_ready pulse -> rx_valid = 0.
REQ-032 Drive rxd low for 5 cycles only -> no byte, frame_err = 0, busy returns to 0 within 10 cycles.
REQ-033 Send 0x3C with stop bit = 0 -> frame_err = 1, rx_valid stays 0; pulse err_clr -> frame_err = 0.
REQ-034 Send 0x01..0x05 back to back with rx_ready = 0 -> overrun = 1; draining yields 0x01, 0x02, 0x03, 0x04, then rx_valid = 0.
REQ-035 FIFO full, rx_ready = 1 on the push cycle of a 5th byte 0x77 -> overrun stays 0, 0x77 delivered last.
REQ-036 Assert reset during data bit 3 -> busy = 0, rx_valid = 0 next cycle; a following 0x5A is received correctly.
